// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: byte/half/word loads and stores with sign/zero
// extension, configurable wait states and a single-cycle response pulse.
module data_mem_ctrl #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   mem [DEPTH];

  logic          accept, dec_err, addr_oor;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word, ld_data, acc_rdata, hold_rdata, wr_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [3:0]    wr_be;
  logic          hold_err;

  assign accept   = req_valid && req_ready;
  assign idx      = req_addr[AW+1:2];
  assign lane     = req_addr[1:0];
  assign addr_oor = |req_addr[31:AW+2];
  assign rd_word  = mem[idx];
  assign ld_byte  = rd_word[{lane, 3'b000} +: 8];
  assign ld_half  = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

  // Access decode: error flags, store byte enables and extended load data
  always_comb begin
    dec_err = addr_oor;
    wr_be   = 4'b0000;
    wr_data = req_wdata;
    ld_data = rd_word;
    case (req_size)
      2'b00: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{req_wdata[7:0]}};
        ld_data = req_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      2'b01: begin
        dec_err = addr_oor | req_addr[0];
        wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
        ld_data = req_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      2'b10: begin
        dec_err = addr_oor | (|lane);
        wr_be   = 4'b1111;
      end
      default: dec_err = 1'b1;
    endcase
    acc_rdata = (dec_err || req_we) ? '0 : ld_data;
  end

  // Array is deliberately not reset; stores commit at the acceptance edge
  always_ff @(posedge clk) begin
    if (accept && req_we && !dec_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_nx = ST_WAIT;
            cnt_nx   = CNT_LOAD;
          end else begin
            state_nx = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) state_nx = ST_RESP;
        else           cnt_nx   = cnt - CW'(1);
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // With zero wait states the response is loaded straight from the decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      hold_rdata <= '0;
      hold_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      req_ready <= (state_nx == ST_IDLE);
      rsp_valid <= (state_nx == ST_RESP);
      if (accept) begin
        hold_rdata <= acc_rdata;
        hold_err   <= dec_err;
      end
      if (state_nx == ST_RESP) begin
        rsp_rdata <= (state == ST_IDLE) ? acc_rdata : hold_rdata;
        rsp_err   <= (state == ST_IDLE) ? dec_err   : hold_err;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (0, 2 and 3 wait states) driven by
// a directed vector table, corner sequences and random traffic vs a byte model.
module tb_data_mem_ctrl;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned NB    = DEPTH * 4;
  localparam int          ND    = 3;
  localparam int unsigned WS_TAB [ND] = '{0, 2, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        rv [ND];
  logic        we [ND];
  logic        ru [ND];
  logic [31:0] ra [ND];
  logic [31:0] wd [ND];
  logic [1:0]  rs [ND];
  logic        rdy [ND];
  logic        vld [ND];
  logic        er  [ND];
  logic [31:0] rd  [ND];

  logic [7:0] mref [ND][NB];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [1:0]  sz;
    bit          u;
    logic [31:0] wdat;
    logic [31:0] erd;
    bit          eerr;
    string       nm;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(WS_TAB[g])) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (rv[g]),
      .req_ready   (rdy[g]),
      .req_we      (we[g]),
      .req_addr    (ra[g]),
      .req_size    (rs[g]),
      .req_unsigned(ru[g]),
      .req_wdata   (wd[g]),
      .rsp_valid   (vld[g]),
      .rsp_rdata   (rd[g]),
      .rsp_err     (er[g])
    );
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: little-endian byte array, result derived from size/alignment rules
  task automatic model(input int d, input bit w, input logic [31:0] a, input logic [1:0] sz,
                       input bit u, input logic [31:0] wdat,
                       output logic [31:0] erd, output bit eerr);
    int unsigned nb;
    logic [31:0] v;
    nb   = 1 << sz;
    eerr = (sz == 2'd3) || ((a % nb) != 0) || ((a / 4) >= DEPTH);
    erd  = '0;
    if (!eerr) begin
      if (w) begin
        for (int i = 0; i < int'(nb); i++) mref[d][a + i] = wdat[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < int'(nb); i++) v[8*i +: 8] = mref[d][a + i];
        if (nb == 1 && !u && v[7])  v[31:8]  = '1;
        if (nb == 2 && !u && v[15]) v[31:16] = '1;
        erd = v;
      end
    end
  endtask

  task automatic add(input bit w, input logic [31:0] a, input logic [1:0] sz, input bit u,
                     input logic [31:0] wdat, input logic [31:0] erd, input bit eerr,
                     input string nm);
    vec_t v;
    v.w = w; v.a = a; v.sz = sz; v.u = u; v.wdat = wdat; v.erd = erd; v.eerr = eerr; v.nm = nm;
    tbl.push_back(v);
  endtask

  // One full request/response, checking ready, latency, payload and pulse width
  task automatic xact(input int d, input bit w, input logic [31:0] a, input logic [1:0] sz,
                      input bit u, input logic [31:0] wdat, input logic [31:0] erd,
                      input bit eerr, input string nm);
    int n;
    bit got;
    n = 0;
    while (!rdy[d] && n < 50) begin @(negedge clk); n++; end
    chk({nm, " ready"}, 32'(rdy[d]), 32'd1);
    rv[d] = 1'b1; we[d] = w; ra[d] = a; rs[d] = sz; ru[d] = u; wd[d] = wdat;
    @(posedge clk);
    #1;
    rv[d] = 1'b0; we[d] = 1'($urandom); ra[d] = $urandom; rs[d] = 2'($urandom);
    ru[d] = 1'($urandom); wd[d] = $urandom;
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (vld[d]) got = 1'b1;
      else        chk({nm, " ready_low"}, 32'(rdy[d]), 32'd0);
    end
    chk({nm, " latency"}, 32'(n), 32'(WS_TAB[d] + 1));
    chk({nm, " rdata"}, rd[d], erd);
    chk({nm, " err"}, 32'(er[d]), 32'(eerr));
    @(negedge clk);
    chk({nm, " pulse_end"}, 32'(vld[d]), 32'd0);
  endtask

  // Accept a word access, then reset while it waits: no response may appear
  task automatic reset_mid(input int d, input bit w, input logic [31:0] a,
                           input logic [31:0] wdat, input string nm);
    @(negedge clk);
    rv[d] = 1'b1; we[d] = w; ra[d] = a; rs[d] = 2'd2; ru[d] = 1'b0; wd[d] = wdat;
    @(posedge clk);
    #1 rv[d] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({nm, " ready_async"}, 32'(rdy[d]), 32'd1);
    chk({nm, " valid_async"}, 32'(vld[d]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk({nm, " no_rsp"}, 32'(vld[d]), 32'd0);
      chk({nm, " ready_idle"}, 32'(rdy[d]), 32'd1);
    end
    chk({nm, " rdata_reset"}, rd[d], 32'd0);
  endtask

  initial begin
    logic [31:0] erd, a, wdat;
    logic [1:0]  sz;
    bit          eerr, w, u;
    int          n, r, nrand;
    bit          got;

    for (int d = 0; d < ND; d++) begin
      rv[d] = 1'b0; we[d] = 1'b0; ru[d] = 1'b0; ra[d] = '0; wd[d] = '0; rs[d] = '0;
    end

    add(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
    add(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");
    add(1'b1, 32'h00, 2'd2, 1'b0, 32'h0BADC0DE, 32'h0, 1'b0, "sw_0");
    add(1'b1, 32'h20, 2'd2, 1'b0, 32'h11223344, 32'h0, 1'b0, "sw_20");
    add(1'b1, 32'h21, 2'd0, 1'b0, 32'hFFFFFF80, 32'h0, 1'b0, "sb_21");
    add(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 32'h11228044, 1'b0, "lw_20");
    add(1'b0, 32'h21, 2'd0, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, "lb_21");
    add(1'b0, 32'h21, 2'd0, 1'b1, 32'h0, 32'h00000080, 1'b0, "lbu_21");
    add(1'b0, 32'h22, 2'd1, 1'b0, 32'h0, 32'h00001122, 1'b0, "lh_22");
    add(1'b0, 32'h20, 2'd1, 1'b0, 32'h0, 32'hFFFF8044, 1'b0, "lh_20");
    add(1'b0, 32'h20, 2'd1, 1'b1, 32'h0, 32'h00008044, 1'b0, "lhu_20");
    add(1'b0, 32'h20, 2'd2, 1'b1, 32'h0, 32'h11228044, 1'b0, "lw_uns_20");
    add(1'b0, 32'h12, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, "lw_mis_12");
    add(1'b0, 32'h13, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1, "lh_mis_13");
    add(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, "size3_ld");
    add(1'b1, 32'h10, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, "size3_st");
    add(1'b1, NB,     2'd2, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1, "sw_oor");
    add(1'b1, 32'h8010, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, "sw_hi_oor");
    add(1'b1, 32'h11, 2'd1, 1'b0, 32'h0000AAAA, 32'h0, 1'b1, "sh_mis_11");
    add(1'b1, 32'h12, 2'd2, 1'b0, 32'h55555555, 32'h0, 1'b1, "sw_mis_12");
    add(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10_kept");
    add(1'b0, 32'h00, 2'd2, 1'b0, 32'h0, 32'h0BADC0DE, 1'b0, "lw_0_kept");
    add(1'b0, 32'h8010, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, "lw_hi_oor");
    add(1'b1, 32'h14, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, "sw_14");
    add(1'b1, 32'h16, 2'd1, 1'b0, 32'h1234CAFE, 32'h0, 1'b0, "sh_16");
    add(1'b0, 32'h14, 2'd2, 1'b0, 32'h0, 32'hCAFE0000, 1'b0, "lw_14");
    add(1'b0, 32'h17, 2'd0, 1'b1, 32'h0, 32'h000000CA, 1'b0, "lbu_17");
    add(1'b0, 32'h17, 2'd0, 1'b0, 32'h0, 32'hFFFFFFCA, 1'b0, "lb_17");
    add(1'b1, NB - 4, 2'd2, 1'b0, 32'h12345678, 32'h0, 1'b0, "sw_last");
    add(1'b0, NB - 1, 2'd0, 1'b1, 32'h0, 32'h00000012, 1'b0, "lbu_last");
    add(1'b0, NB,     2'd1, 1'b0, 32'h0, 32'h0, 1'b1, "lh_oor");

    // Reset values
    #12;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d reset ready", d), 32'(rdy[d]), 32'd1);
      chk($sformatf("d%0d reset valid", d), 32'(vld[d]), 32'd0);
      chk($sformatf("d%0d reset rdata", d), rd[d], 32'd0);
      chk($sformatf("d%0d reset err", d), 32'(er[d]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors on every wait-state build
    for (int d = 0; d < ND; d++) begin
      foreach (tbl[i]) begin
        model(d, tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].u, tbl[i].wdat, erd, eerr);
        xact(d, tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].u, tbl[i].wdat, tbl[i].erd, tbl[i].eerr,
             $sformatf("d%0d %s", d, tbl[i].nm));
      end
    end

    // Request held through the busy window must not be accepted twice
    @(negedge clk);
    rv[2] = 1'b1; we[2] = 1'b0; ra[2] = 32'h10; rs[2] = 2'd2; ru[2] = 1'b0;
    @(posedge clk);
    #1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (vld[2]) got = 1'b1;
      else        chk("hold ready_low", 32'(rdy[2]), 32'd0);
    end
    rv[2] = 1'b0;
    chk("hold latency", 32'(n), 32'd4);
    chk("hold rdata", rd[2], 32'hDEADBEEF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("hold no_extra_rsp", 32'(vld[2]), 32'd0);
      chk("hold ready_idle", 32'(rdy[2]), 32'd1);
    end

    // Reset during the wait phase of a store and of a load
    for (int d = 1; d < ND; d++) begin
      model(d, 1'b1, 32'h40, 2'd2, 1'b0, 32'hA5A55A5A, erd, eerr);
      reset_mid(d, 1'b1, 32'h40, 32'hA5A55A5A, $sformatf("d%0d rst_sw", d));
      reset_mid(d, 1'b0, 32'h40, 32'h0, $sformatf("d%0d rst_lw", d));
      xact(d, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'hA5A55A5A, 1'b0,
           $sformatf("d%0d rst_readback", d));
    end

    // Random traffic: fill every word, then mixed accesses against the model
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        wdat = $urandom;
        model(d, 1'b1, 32'(i * 4), 2'd2, 1'b0, wdat, erd, eerr);
        xact(d, 1'b1, 32'(i * 4), 2'd2, 1'b0, wdat, erd, eerr, $sformatf("d%0d init", d));
      end
      nrand = (d == 2) ? 200 : 1000;
      for (int i = 0; i < nrand; i++) begin
        r = int'($urandom_range(0, 9));
        a = (r == 0) ? $urandom : $urandom_range(0, NB + 15);
        r = int'($urandom_range(0, 9));
        sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        w = 1'($urandom);
        u = 1'($urandom);
        wdat = $urandom;
        model(d, w, a, sz, u, wdat, erd, eerr);
        xact(d, w, a, sz, u, wdat, erd, eerr, $sformatf("d%0d rand%0d", d, i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
